mgt_link_ctrl: RTL and testbench
================================

// Module: mgt_link_ctrl
// PURPOSE
// - Reset/bring-up sequencer and link supervisor for the SFP GTP transceiver.
// - Sits between the GTP wizard and the SFP cage:
//   - drives the TX and RX resets and sfp_tx_dis;
//   - watches sfp_loss, the reset-done flags, byte alignment and the RX error strobe;
//   - reports link_up to the rest of top.
// - Recovers automatically from loss of signal and error bursts.
// - Gives up into a sticky FAIL state after repeated bring-up timeouts.
// PARAMETERS
// RST_CYC    16      cycles a GT reset is held asserted (>=1)
// DONE_TMO   50000   cycles to wait for tx/rx_reset_done before a timeout
// ALIGN_TMO  100000  cycles to wait for rx_aligned before a timeout
// LOS_DEB    64      cycles the synced sfp_loss must be stable before it is accepted
// ERR_WIN    65536   error-rate window length, in cycles
// ERR_MAX    8       number of rx_err pulses within one window that forces a relink
// MAX_RETRY  3       bring-up timeouts tolerated before FAIL
// PORTS
// clk            in   1   free-running system clock; all logic lives in this domain
// rst            in   1   synchronous reset, active-high
// sfp_loss       in   1   SFP LOS pin; asynchronous, passed through a 2-FF synchronizer inside
// tx_reset_done  in   1   GT TX reset complete (level)
// rx_reset_done  in   1   GT RX reset complete (level)
// rx_aligned     in   1   RX comma / byte alignment achieved (level)
// rx_err         in   1   one-cycle strobe per disparity or not-in-table error
// gt_tx_reset    out  1   GT TX reset
// gt_rx_reset    out  1   GT RX reset
// sfp_tx_dis     out  1   SFP transmitter disable
// link_up        out  1   link usable
// fail           out  1   sticky bring-up failure
// state          out  3   current FSM state encoding (for debug)
// BEHAVIOUR
// - Reset values, while rst=1 and on the cycle after:
//   gt_tx_reset=1, gt_rx_reset=1, sfp_tx_dis=1, link_up=0, fail=0, state=TX_RST.
//   All counters, including retry, are cleared to 0.
// - los = the synced sfp_loss level once it has been stable for LOS_DEB consecutive cycles.
//   The synchronizer adds 2 cycles of latency.
// - FSM states and encodings:
//   - TX_RST(0): gt_tx_reset=1 and gt_rx_reset=1 for RST_CYC cycles, then go to TX_WAIT.
//   - TX_WAIT(1): gt_tx_reset=0 and sfp_tx_dis=0.
//     - tx_reset_done=1 -> RX_RST.
//     - After DONE_TMO cycles -> timeout, return to TX_RST.
//   - RX_RST(2): gt_rx_reset=1 for RST_CYC cycles.
//     - Exit to RX_WAIT, or to LOS_WAIT if los=1 at the end of the hold.
//   - RX_WAIT(3): gt_rx_reset=0.
//     - rx_reset_done=1 -> ALIGN.
//     - After DONE_TMO cycles -> timeout, return to RX_RST.
//   - ALIGN(4): rx_aligned=1 -> UP. After ALIGN_TMO cycles -> timeout, return to RX_RST.
//   - UP(5): link_up=1 and retry is cleared. Leave to RX_RST on either:
//     - rx_aligned=0, or
//     - ERR_MAX rx_err pulses counted within the current ERR_WIN window.
//     The window timer and error count restart on window expiry and on every entry to UP.
//   - LOS_WAIT(6): gt_rx_reset=1. When los=0 -> RX_RST.
//   - FAIL(7): gt_tx_reset=1, gt_rx_reset=1, sfp_tx_dis=1, fail=1. Only rst leaves FAIL.
// - Timeouts:
//   - Each timeout increments retry.
//   - A timeout when retry==MAX_RETRY goes to FAIL instead of retrying.
//   - So the FSM makes MAX_RETRY retries and enters FAIL on timeout number MAX_RETRY+1.
// - LOS and relinks:
//   - los=1 in RX_WAIT, ALIGN or UP -> LOS_WAIT on the next cycle. This has the highest
//     priority and does not count as a retry.
//   - Link drops out of UP (alignment loss or error burst) do not count as retries.
// - Simultaneous events:
//   - los beats timeout, error burst and alignment loss in the same cycle.
//   - In UP, an rx_err arriving on the window-expiry cycle counts toward the new window.
// - link_up is registered. It falls on the cycle after UP is left and rises on the cycle
//   after UP is entered.
// - Counters are wide enough for their parameter: $clog2(param+1) bits each, and they
//   never wrap.
// - rst asserted in any state, mid-sequence included, restarts from TX_RST with
//   retry=0 and fail=0.
// CONFIGURATION
// - MGT_LINK_STATS_EN defined adds:
//   - output drop_cnt[15:0]: UP exits, saturating at 16'hFFFF.
//   - output los_cnt[15:0]: LOS_WAIT entries, saturating at 16'hFFFF.
//   - Both reset to 0 on rst.
// - MGT_LINK_STATS_EN undefined: those ports and their logic are absent; all other
//   behaviour is identical.
// TESTING (RST_CYC=4, DONE_TMO=100, ALIGN_TMO=200, LOS_DEB=8, ERR_WIN=64, ERR_MAX=4,
//          MAX_RETRY=3)
// 1. Bring-up: release rst; tx_done at cycle 10, rx_done at cycle 30, aligned at
//    cycle 40 -> link_up=1 within 2 cycles of aligned; sfp_tx_dis=0; state=5.
// 2. LOS: from UP, sfp_loss=1 for 20 cycles -> link_up=0 exactly 2+8+1 cycles after the
//    edge; gt_rx_reset=1; state=6; loss released -> link re-reaches UP; retry unchanged.
// 3. Glitch: sfp_loss=1 for 5 cycles (< LOS_DEB) -> link_up stays 1; los_cnt unchanged
//    with _EN.
// 4. Error burst: 4 rx_err pulses within 64 cycles -> relink via RX_RST; 3 pulses per
//    window repeated -> link stays up.
// 5. Fail: tx_reset_done held 0 -> 4 timeouts (104 cycles each) then FAIL; fail=1 and
//    sfp_tx_dis=1; rst clears.
// 6. Mid-sequence reset: rst pulsed in ALIGN -> all outputs at reset values next cycle;
//    drop_cnt=0 with _EN.

Source files
------------

// File: rtl/mgt_link_ctrl.sv
// mgt_link_ctrl: SFP GTP reset/bring-up sequencer and link supervisor.
// Ports:
//   in:  clk, rst (sync, active-high), sfp_loss (async LOS pin),
//        tx_reset_done, rx_reset_done, rx_aligned, rx_err (strobe)
//   out: gt_tx_reset, gt_rx_reset, sfp_tx_dis, link_up, fail, state[2:0]
// Optional: define MGT_LINK_STATS_EN to add drop_cnt[15:0] and los_cnt[15:0].
module mgt_link_ctrl #(
  parameter int RST_CYC   = 16,
  parameter int DONE_TMO  = 50000,
  parameter int ALIGN_TMO = 100000,
  parameter int LOS_DEB   = 64,
  parameter int ERR_WIN   = 65536,
  parameter int ERR_MAX   = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfp_loss,
  input  logic       tx_reset_done,
  input  logic       rx_reset_done,
  input  logic       rx_aligned,
  input  logic       rx_err,
  output logic       gt_tx_reset,
  output logic       gt_rx_reset,
  output logic       sfp_tx_dis,
  output logic       link_up,
  output logic       fail,
  output logic [2:0] state
`ifdef MGT_LINK_STATS_EN
  ,
  output logic [15:0] drop_cnt,
  output logic [15:0] los_cnt
`endif
);

  localparam int TMO_MAX =
    (ALIGN_TMO > DONE_TMO) ? ALIGN_TMO : DONE_TMO;
  localparam int HW = $clog2(RST_CYC + 1);
  localparam int TW = $clog2(TMO_MAX + 1);
  localparam int DW = $clog2(LOS_DEB + 1);
  localparam int WW = $clog2(ERR_WIN + 1);
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_TX_RST   = 3'd0,
    S_TX_WAIT  = 3'd1,
    S_RX_RST   = 3'd2,
    S_RX_WAIT  = 3'd3,
    S_ALIGN    = 3'd4,
    S_UP       = 3'd5,
    S_LOS_WAIT = 3'd6,
    S_FAIL     = 3'd7
  } st_t;

  st_t st, nxt;

  logic          sync1, sync2, los;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt, err_nxt;
  logic [RW-1:0] retry;
  logic          hold_done, done_tmo, align_tmo;
  logic          win_end, burst, tmo;

  // LOS: 2-FF sync, then accept a new level only after it
  // has differed from the current one for LOS_DEB cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      los     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= sfp_loss;
      sync2 <= sync1;
      if (sync2 == los) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(LOS_DEB - 1)) begin
        los     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign hold_done = hold_cnt == HW'(RST_CYC - 1);
  assign done_tmo  = tmo_cnt == TW'(DONE_TMO - 1);
  assign align_tmo = tmo_cnt == TW'(ALIGN_TMO - 1);
  assign win_end   = win_cnt == WW'(ERR_WIN - 1);

  // An error on the expiry cycle belongs to the new window.
  assign err_nxt = (win_end ? '0 : err_cnt) + EW'(rx_err);
  assign burst   = err_nxt >= EW'(ERR_MAX);

  always_comb begin
    nxt = st;
    tmo = 1'b0;
    case (st)
      S_TX_RST:
        if (hold_done) nxt = S_TX_WAIT;
      S_TX_WAIT:
        if (tx_reset_done) nxt = S_RX_RST;
        else if (done_tmo) tmo = 1'b1;
      S_RX_RST:
        if (hold_done) nxt = los ? S_LOS_WAIT : S_RX_WAIT;
      S_RX_WAIT:
        if (los) nxt = S_LOS_WAIT;
        else if (rx_reset_done) nxt = S_ALIGN;
        else if (done_tmo) tmo = 1'b1;
      S_ALIGN:
        if (los) nxt = S_LOS_WAIT;
        else if (rx_aligned) nxt = S_UP;
        else if (align_tmo) tmo = 1'b1;
      S_UP:
        if (los) nxt = S_LOS_WAIT;
        else if (!rx_aligned || burst) nxt = S_RX_RST;
      S_LOS_WAIT:
        if (!los) nxt = S_RX_RST;
      default: nxt = st;
    endcase
    if (tmo) begin
      if (retry == RW'(MAX_RETRY)) nxt = S_FAIL;
      else if (st == S_TX_WAIT) nxt = S_TX_RST;
      else nxt = S_RX_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_TX_RST;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      win_cnt     <= '0;
      err_cnt     <= '0;
      retry       <= '0;
      gt_tx_reset <= 1'b1;
      gt_rx_reset <= 1'b1;
      sfp_tx_dis  <= 1'b1;
      link_up     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt != st) begin
        hold_cnt <= '0;
        tmo_cnt  <= '0;
        win_cnt  <= '0;
        err_cnt  <= '0;
      end else begin
        if (!hold_done)
          hold_cnt <= hold_cnt + 1'b1;
        if (tmo_cnt != TW'(TMO_MAX - 1))
          tmo_cnt <= tmo_cnt + 1'b1;
        if (st == S_UP) begin
          win_cnt <= win_end ? '0 : win_cnt + 1'b1;
          err_cnt <= err_nxt;
        end
      end
      if (tmo && retry != RW'(MAX_RETRY))
        retry <= retry + 1'b1;
      else if (nxt == S_UP)
        retry <= '0;
      gt_tx_reset <= nxt == S_TX_RST || nxt == S_FAIL;
      gt_rx_reset <= nxt == S_TX_RST || nxt == S_RX_RST ||
                     nxt == S_LOS_WAIT || nxt == S_FAIL;
      sfp_tx_dis  <= nxt == S_TX_RST || nxt == S_FAIL;
      link_up     <= nxt == S_UP;
      fail        <= nxt == S_FAIL;
    end
  end

  assign state = st;

`ifdef MGT_LINK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      los_cnt  <= '0;
    end else begin
      if (st == S_UP && nxt != S_UP && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
      if (st != S_LOS_WAIT && nxt == S_LOS_WAIT &&
          los_cnt != 16'hFFFF)
        los_cnt <= los_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mgt_link_ctrl.sv
// tb_mgt_link_ctrl: directed bench for mgt_link_ctrl.
// Small parameters; expected values are hand-computed cycle counts.
module tb_mgt_link_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sfp_loss;
  logic       tx_reset_done;
  logic       rx_reset_done;
  logic       rx_aligned;
  logic       rx_err;
  logic       gt_tx_reset;
  logic       gt_rx_reset;
  logic       sfp_tx_dis;
  logic       link_up;
  logic       fail;
  logic [2:0] state;
`ifdef MGT_LINK_STATS_EN
  logic [15:0] drop_cnt;
  logic [15:0] los_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  mgt_link_ctrl #(
    .RST_CYC  (4),
    .DONE_TMO (100),
    .ALIGN_TMO(200),
    .LOS_DEB  (8),
    .ERR_WIN  (64),
    .ERR_MAX  (4),
    .MAX_RETRY(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sfp_loss     (sfp_loss),
    .tx_reset_done(tx_reset_done),
    .rx_reset_done(rx_reset_done),
    .rx_aligned   (rx_aligned),
    .rx_err       (rx_err),
    .gt_tx_reset  (gt_tx_reset),
    .gt_rx_reset  (gt_rx_reset),
    .sfp_tx_dis   (sfp_tx_dis),
    .link_up      (link_up),
    .fail         (fail),
    .state        (state)
`ifdef MGT_LINK_STATS_EN
    ,
    .drop_cnt     (drop_cnt),
    .los_cnt      (los_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sfp_loss = 1'b0;
    tx_reset_done = 1'b0;
    rx_reset_done = 1'b0;
    rx_aligned = 1'b0;
    rx_err = 1'b0;
    tick(3);
    n_chk++;
    if ({gt_tx_reset, gt_rx_reset, sfp_tx_dis,
         link_up, fail} !== 5'b11100) begin
      n_err++;
      $display("FAIL rst_outs: got %b expected 11100",
        {gt_tx_reset, gt_rx_reset, sfp_tx_dis, link_up, fail});
    end
    n_chk++;
    if (state !== 3'd0) begin
      n_err++;
      $display("FAIL rst_state: got %0d expected 0", state);
    end
    rst = 1'b0;
    tick(1);
    n_chk++;
    if (state !== 3'd0 || gt_tx_reset !== 1'b1) begin
      n_err++;
      $display("FAIL rst_after: state %0d txr %b expected 0 1",
        state, gt_tx_reset);
    end
  endtask

  task automatic test_bringup();
    tick(9);
    n_chk++;
    if (state !== 3'd1 || gt_tx_reset !== 1'b0 ||
        sfp_tx_dis !== 1'b0) begin
      n_err++;
      $display("FAIL tx_wait: state %0d txr %b dis %b expected 1 0 0",
        state, gt_tx_reset, sfp_tx_dis);
    end
    tx_reset_done = 1'b1;
    tick(2);
    n_chk++;
    if (state !== 3'd2 || gt_rx_reset !== 1'b1) begin
      n_err++;
      $display("FAIL rx_rst: state %0d rxr %b expected 2 1",
        state, gt_rx_reset);
    end
    tick(18);
    n_chk++;
    if (state !== 3'd3 || gt_rx_reset !== 1'b0) begin
      n_err++;
      $display("FAIL rx_wait: state %0d rxr %b expected 3 0",
        state, gt_rx_reset);
    end
    rx_reset_done = 1'b1;
    tick(10);
    n_chk++;
    if (state !== 3'd4 || link_up !== 1'b0) begin
      n_err++;
      $display("FAIL align: state %0d up %b expected 4 0",
        state, link_up);
    end
    rx_aligned = 1'b1;
    tick(1);
    n_chk++;
    if (state !== 3'd5 || link_up !== 1'b1 ||
        sfp_tx_dis !== 1'b0) begin
      n_err++;
      $display("FAIL up: state %0d up %b dis %b expected 5 1 0",
        state, link_up, sfp_tx_dis);
    end
  endtask

  task automatic test_los();
    sfp_loss = 1'b1;
    tick(10);
    n_chk++;
    if (link_up !== 1'b1) begin
      n_err++;
      $display("FAIL los_early: up %b expected 1", link_up);
    end
    tick(1);
    n_chk++;
    if (link_up !== 1'b0 || state !== 3'd6 ||
        gt_rx_reset !== 1'b1) begin
      n_err++;
      $display("FAIL los_drop: up %b state %0d rxr %b expected 0 6 1",
        link_up, state, gt_rx_reset);
    end
    tick(9);
    sfp_loss = 1'b0;
    tick(10);
    n_chk++;
    if (state !== 3'd6) begin
      n_err++;
      $display("FAIL los_hold: state %0d expected 6", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd2) begin
      n_err++;
      $display("FAIL los_exit: state %0d expected 2", state);
    end
    tick(5);
    n_chk++;
    if (state !== 3'd4) begin
      n_err++;
      $display("FAIL los_align: state %0d expected 4", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd5 || link_up !== 1'b1) begin
      n_err++;
      $display("FAIL los_relink: state %0d up %b expected 5 1",
        state, link_up);
    end
  endtask

  task automatic test_glitch();
    int up_cyc = 0;
    for (int i = 0; i < 25; i++) begin
      sfp_loss = (i < 5);
      tick(1);
      if (link_up === 1'b1) up_cyc++;
    end
    n_chk++;
    if (up_cyc !== 25 || state !== 3'd5) begin
      n_err++;
      $display("FAIL glitch: up cycles %0d state %0d expected 25 5",
        up_cyc, state);
    end
`ifdef MGT_LINK_STATS_EN
    n_chk++;
    if (los_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL glitch_los_cnt: got %0d expected 1", los_cnt);
    end
`endif
  endtask

  task automatic test_err_burst();
    rx_err = 1'b1;
    tick(3);
    n_chk++;
    if (state !== 3'd5) begin
      n_err++;
      $display("FAIL burst3: state %0d expected 5", state);
    end
    tick(1);
    rx_err = 1'b0;
    n_chk++;
    if (state !== 3'd2 || link_up !== 1'b0) begin
      n_err++;
      $display("FAIL burst4: state %0d up %b expected 2 0",
        state, link_up);
    end
    tick(5);
    n_chk++;
    if (state !== 3'd4) begin
      n_err++;
      $display("FAIL burst_align: state %0d expected 4", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd5 || link_up !== 1'b1) begin
      n_err++;
      $display("FAIL burst_relink: state %0d up %b expected 5 1",
        state, link_up);
    end
  endtask

  // Window starts on the UP entry just made. Three windows with
  // 3 errors each hold the link; then 2 errors at the end of a
  // window, one on the expiry cycle and 3 more must relink on
  // the last, since the expiry-cycle error opens the new window.
  task automatic test_err_window();
    int drops = 0;
    for (int i = 0; i < 287; i++) begin
      int m;
      m = i % 64;
      if (i < 192)
        rx_err = (m == 5 || m == 25 || m == 45);
      else
        rx_err = (i == 253 || i == 254 || i == 255 ||
                  i == 266 || i == 276 || i == 286);
      tick(1);
      rx_err = 1'b0;
      if (i < 286 && (state !== 3'd5 || link_up !== 1'b1))
        drops++;
    end
    n_chk++;
    if (drops !== 0) begin
      n_err++;
      $display("FAIL win_hold: early drop cycles %0d expected 0",
        drops);
    end
    n_chk++;
    if (state !== 3'd2 || link_up !== 1'b0) begin
      n_err++;
      $display("FAIL win_edge: state %0d up %b expected 2 0",
        state, link_up);
    end
`ifdef MGT_LINK_STATS_EN
    n_chk++;
    if (drop_cnt !== 16'd3) begin
      n_err++;
      $display("FAIL drop_cnt: got %0d expected 3", drop_cnt);
    end
`endif
  endtask

  task automatic test_fail();
    rst = 1'b1;
    tx_reset_done = 1'b0;
    rx_reset_done = 1'b0;
    rx_aligned = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(103);
    n_chk++;
    if (state !== 3'd1) begin
      n_err++;
      $display("FAIL tmo1_pre: state %0d expected 1", state);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd0 || fail !== 1'b0) begin
      n_err++;
      $display("FAIL tmo1: state %0d fail %b expected 0 0",
        state, fail);
    end
    tick(311);
    n_chk++;
    if (state !== 3'd1 || fail !== 1'b0) begin
      n_err++;
      $display("FAIL tmo4_pre: state %0d fail %b expected 1 0",
        state, fail);
    end
    tick(1);
    n_chk++;
    if (state !== 3'd7 || fail !== 1'b1 || sfp_tx_dis !== 1'b1 ||
        gt_tx_reset !== 1'b1 || gt_rx_reset !== 1'b1 ||
        link_up !== 1'b0) begin
      n_err++;
      $display("FAIL fail_ent: state %0d fail %b dis %b expected 7 1 1",
        state, fail, sfp_tx_dis);
    end
    tx_reset_done = 1'b1;
    rx_reset_done = 1'b1;
    tick(20);
    n_chk++;
    if (state !== 3'd7 || fail !== 1'b1) begin
      n_err++;
      $display("FAIL fail_sticky: state %0d fail %b expected 7 1",
        state, fail);
    end
    rst = 1'b1;
    tick(1);
    n_chk++;
    if (state !== 3'd0 || fail !== 1'b0) begin
      n_err++;
      $display("FAIL fail_clear: state %0d fail %b expected 0 0",
        state, fail);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b0;
    tick(10);
    n_chk++;
    if (state !== 3'd4 || sfp_tx_dis !== 1'b0) begin
      n_err++;
      $display("FAIL mid_align: state %0d dis %b expected 4 0",
        state, sfp_tx_dis);
    end
    rst = 1'b1;
    tick(1);
    n_chk++;
    if ({gt_tx_reset, gt_rx_reset, sfp_tx_dis,
         link_up, fail} !== 5'b11100 || state !== 3'd0) begin
      n_err++;
      $display("FAIL mid_rst: outs %b state %0d expected 11100 0",
        {gt_tx_reset, gt_rx_reset, sfp_tx_dis, link_up, fail},
        state);
    end
`ifdef MGT_LINK_STATS_EN
    n_chk++;
    if (drop_cnt !== 16'd0 || los_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mid_stats: drop %0d los %0d expected 0 0",
        drop_cnt, los_cnt);
    end
`endif
    rst = 1'b0;
    tick(1);
    n_chk++;
    if (state !== 3'd0 || gt_tx_reset !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after: state %0d txr %b expected 0 1",
        state, gt_tx_reset);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bringup();
    test_los();
    test_glitch();
    test_err_burst();
    test_err_window();
    test_fail();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_err);
    $finish;
  end

endmodule
